// File: rtl/wb_arbiter.sv
// Writeback arbiter that merges N_SRC result producers onto WRITE_PORTS regfile write ports.
// Each source holds one buffered result. Grants rotate round-robin, and two grants in the
// same cycle never target the same register.
// Optional feature: define WB_FWD_EN to add a combinational forwarding lookup of the
// results being written this cycle (raddr / fwd_hit / fwd_data).
module wb_arbiter #(
    parameter int unsigned N_SRC       = 3,
    parameter int unsigned WRITE_PORTS = 1,
    parameter int unsigned READ_PORTS  = 2,
    localparam int unsigned AW         = 5,
    localparam int unsigned DW         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_SRC-1:0]                  src_valid,
    input  logic [N_SRC-1:0][AW-1:0]          src_waddr,
    input  logic [N_SRC-1:0][DW-1:0]          src_wdata,
    output logic [N_SRC-1:0]                  src_ready,
    output logic [WRITE_PORTS-1:0]            we,
    output logic [WRITE_PORTS-1:0][AW-1:0]    waddr,
    output logic [WRITE_PORTS-1:0][DW-1:0]    wrdata,
    output logic                              idle
`ifdef WB_FWD_EN
    ,
    input  logic [READ_PORTS-1:0][AW-1:0]     raddr,
    output logic [READ_PORTS-1:0]             fwd_hit,
    output logic [READ_PORTS-1:0][DW-1:0]     fwd_data
`endif
);

    localparam int unsigned PW = $clog2(N_SRC);

    if (N_SRC < 2 || N_SRC > 8 || WRITE_PORTS < 1 || WRITE_PORTS > 2 || READ_PORTS < 1) begin : g_bad_cfg
        $error("wb_arbiter: illegal parameter set");
    end

    logic [N_SRC-1:0]           buf_valid;
    logic [N_SRC-1:0][AW-1:0]   buf_addr;
    logic [N_SRC-1:0][DW-1:0]   buf_data;
    logic [PW-1:0]              rr_ptr;
    logic [PW-1:0]              rr_next;
    logic [N_SRC-1:0]           grant;

    // Round-robin grant from rr_ptr, skipping buffers whose address is already being written.
    always_comb begin : arbitration
        int unsigned n_grant;
        int unsigned idx;
        logic        clash;
        grant   = '0;
        we      = '0;
        waddr   = '0;
        wrdata  = '0;
        rr_next = rr_ptr;
        n_grant = 0;
        idx     = 0;
        clash   = 1'b0;
        if (!rst) begin
            for (int unsigned j = 0; j < N_SRC; j++) begin
                idx = 32'(rr_ptr) + j;
                if (idx >= N_SRC) begin
                    idx = idx - N_SRC;
                end
                for (int unsigned i = 0; i < N_SRC; i++) begin
                    if (i == idx && buf_valid[i] && n_grant < WRITE_PORTS) begin
                        clash = 1'b0;
                        for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                            if (k < n_grant && waddr[k] == buf_addr[i]) begin
                                clash = 1'b1;
                            end
                        end
                        if (!clash) begin
                            grant[i] = 1'b1;
                            for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                                if (k == n_grant) begin
                                    we[k]     = 1'b1;
                                    waddr[k]  = buf_addr[i];
                                    wrdata[k] = buf_data[i];
                                end
                            end
                            rr_next = (i == N_SRC - 1) ? '0 : PW'(i + 1);
                            n_grant = n_grant + 1;
                        end
                    end
                end
            end
        end
    end

    // A source may hand over a result when its buffer is empty or being drained this cycle.
    always_comb begin : handshake
        src_ready = rst ? '1 : (~buf_valid | grant);
        idle      = rst | ~(|buf_valid);
    end

    // Buffer load / drain and round-robin pointer update; writes to register 0 are dropped.
    always_ff @(posedge clk) begin : buffers
        if (rst) begin
            buf_valid <= '0;
            buf_addr  <= '0;
            buf_data  <= '0;
            rr_ptr    <= '0;
        end else begin
            rr_ptr <= rr_next;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (src_valid[i] && src_ready[i] && src_waddr[i] != '0) begin
                    buf_valid[i] <= 1'b1;
                    buf_addr[i]  <= src_waddr[i];
                    buf_data[i]  <= src_wdata[i];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef WB_FWD_EN
    // Forward the data being written this cycle; the highest write port wins on a double hit.
    always_comb begin : forwarding
        fwd_hit  = '0;
        fwd_data = '0;
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
                if (raddr[r] != '0 && we[k] && waddr[k] == raddr[r]) begin
                    fwd_hit[r]  = 1'b1;
                    fwd_data[r] = wrdata[k];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: one instance with one write port, one with two write ports, sharing
// the same inputs. A vector table and hand-written sequences cover the named scenarios.
// A high-level buffer/round-robin model checks every cycle, including a randomized phase.
module tb_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [2:0]           src_valid;
    logic [2:0][4:0]      src_waddr;
    logic [2:0][31:0]     src_wdata;

    logic [2:0]           rdy1, rdy2;
    logic [0:0]           we1;
    logic [0:0][4:0]      waddr1;
    logic [0:0][31:0]     wrdata1;
    logic                 idle1;
    logic [1:0]           we2;
    logic [1:0][4:0]      waddr2;
    logic [1:0][31:0]     wrdata2;
    logic                 idle2;
`ifdef WB_FWD_EN
    logic [1:0][4:0]      raddr;
    logic [1:0]           hit1, hit2;
    logic [1:0][31:0]     fd1, fd2;
`endif

    wb_arbiter #(.N_SRC(3), .WRITE_PORTS(1), .READ_PORTS(2)) dut1 (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_waddr(src_waddr), .src_wdata(src_wdata),
        .src_ready(rdy1), .we(we1), .waddr(waddr1), .wrdata(wrdata1), .idle(idle1)
`ifdef WB_FWD_EN
        , .raddr(raddr), .fwd_hit(hit1), .fwd_data(fd1)
`endif
    );

    wb_arbiter #(.N_SRC(3), .WRITE_PORTS(2), .READ_PORTS(2)) dut2 (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_waddr(src_waddr), .src_wdata(src_wdata),
        .src_ready(rdy2), .we(we2), .waddr(waddr2), .wrdata(wrdata2), .idle(idle2)
`ifdef WB_FWD_EN
        , .raddr(raddr), .fwd_hit(hit2), .fwd_data(fd2)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-instance (w=0 one port, w=1 two ports) buffers and scan pointer.
    bit          mv [2][3];
    logic [4:0]  ma [2][3];
    logic [31:0] md [2][3];
    int          mrr[2];
    bit          pg [2][3];
    bit          pwe[2][2];
    logic [4:0]  pa [2][2];
    logic [31:0] pd [2][2];
    bit          prdy[2][3];
    bit          pidle[2];
    int          plast[2];
    bit          pany[2];

    task automatic predict();
        for (int w = 0; w < 2; w++) begin
            int cnt;
            cnt      = 0;
            pany[w]  = 0;
            plast[w] = 0;
            for (int k = 0; k < 2; k++) begin
                pwe[w][k] = 0; pa[w][k] = '0; pd[w][k] = '0;
            end
            for (int i = 0; i < 3; i++) pg[w][i] = 0;
            if (!rst) begin
                for (int j = 0; j < 3; j++) begin
                    int  i;
                    bit  clash;
                    i = (mrr[w] + j) % 3;
                    clash = 0;
                    for (int k = 0; k < cnt; k++) if (pa[w][k] == ma[w][i]) clash = 1;
                    if (mv[w][i] && cnt < w + 1 && !clash) begin
                        pg[w][i] = 1;
                        pwe[w][cnt] = 1; pa[w][cnt] = ma[w][i]; pd[w][cnt] = md[w][i];
                        cnt++;
                        plast[w] = i;
                        pany[w]  = 1;
                    end
                end
            end
            pidle[w] = rst || !(mv[w][0] || mv[w][1] || mv[w][2]);
            for (int i = 0; i < 3; i++) prdy[w][i] = rst || !mv[w][i] || pg[w][i];
        end
    endtask

    task automatic model_update();
        for (int w = 0; w < 2; w++) begin
            if (rst) begin
                for (int i = 0; i < 3; i++) mv[w][i] = 0;
                mrr[w] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (src_valid[i] && prdy[w][i] && src_waddr[i] != 5'd0) begin
                        mv[w][i] = 1; ma[w][i] = src_waddr[i]; md[w][i] = src_wdata[i];
                    end else if (pg[w][i]) begin
                        mv[w][i] = 0;
                    end
                end
                if (pany[w]) mrr[w] = (plast[w] + 1) % 3;
            end
        end
    endtask

    // Wait for the sampling edge, then compare both instances against the model.
    task automatic sample();
        @(negedge clk);
        predict();
        chk("m1_we",     64'(we1),         64'(pwe[0][0]));
        chk("m1_waddr",  64'(waddr1[0]),   64'(pa[0][0]));
        chk("m1_wrdata", 64'(wrdata1[0]),  64'(pd[0][0]));
        chk("m1_ready",  64'(rdy1),        64'({prdy[0][2], prdy[0][1], prdy[0][0]}));
        chk("m1_idle",   64'(idle1),       64'(pidle[0]));
        chk("m2_we",     64'(we2),         64'({pwe[1][1], pwe[1][0]}));
        chk("m2_waddr",  64'(waddr2),      64'({pa[1][1], pa[1][0]}));
        chk("m2_wrdata", 64'(wrdata2),     64'({pd[1][1], pd[1][0]}));
        chk("m2_ready",  64'(rdy2),        64'({prdy[1][2], prdy[1][1], prdy[1][0]}));
        chk("m2_idle",   64'(idle2),       64'(pidle[1]));
`ifdef WB_FWD_EN
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 2; w++) begin
                bit          eh;
                logic [31:0] ed;
                eh = 0; ed = '0;
                for (int k = 0; k < w + 1; k++) begin
                    if (raddr[r] != 5'd0 && pwe[w][k] && pa[w][k] == raddr[r]) begin
                        eh = 1; ed = pd[w][k];
                    end
                end
                chk($sformatf("m%0d_fwd_hit%0d", w + 1, r),
                    64'(w == 0 ? hit1[r] : hit2[r]), 64'(eh));
                chk($sformatf("m%0d_fwd_data%0d", w + 1, r),
                    64'(w == 0 ? fd1[r] : fd2[r]), 64'(ed));
            end
        end
`endif
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input logic [2:0] v,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        rst = r;
        src_valid = v;
        src_waddr[0] = a0; src_waddr[1] = a1; src_waddr[2] = a2;
        src_wdata[0] = d0; src_wdata[1] = d1; src_wdata[2] = d2;
    endtask

    typedef struct {
        bit          r;
        logic [2:0]  v;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        bit          e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        bit          e_idle;
        logic [2:0]  e_rdy;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit r, logic [2:0] v, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                bit e_we, logic [4:0] e_addr, logic [31:0] e_data,
                                bit e_idle, logic [2:0] e_rdy);
        vec_t t;
        t.r = r; t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.d0 = d0; t.d1 = d1; t.d2 = d2;
        t.e_we = e_we; t.e_addr = e_addr; t.e_data = e_data; t.e_idle = e_idle; t.e_rdy = e_rdy;
        return t;
    endfunction

    initial begin
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
`ifdef WB_FWD_EN
        raddr = '0;
`endif
        // Expected outputs of the single-write-port instance in the cycle each row is applied.
        tbl[0]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[1]  = mk(0, 3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0,      0, 0, 0,            1, 3'b111);
        tbl[2]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 5, 32'hDEADBEEF, 0, 3'b111);
        tbl[3]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[4]  = mk(1, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[5]  = mk(0, 3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33,  0, 0, 0,            1, 3'b111);
        tbl[6]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 1, 32'h11,       0, 3'b001);
        tbl[7]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 2, 32'h22,       0, 3'b011);
        tbl[8]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3, 32'h33,       0, 3'b111);
        tbl[9]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[10] = mk(0, 3'b010, 0, 0, 0, 0, 32'h1234, 0,          0, 0, 0,            1, 3'b111);
        tbl[11] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[12] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[13] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[14] = mk(0, 3'b111, 4, 5, 6, 32'h44, 32'h55, 32'h66,  0, 0, 0,            1, 3'b111);
        tbl[15] = mk(1, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[16] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);
        tbl[17] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 0, 0, 0,            1, 3'b111);

        for (int n = 0; n < 18; n++) begin
            drive(tbl[n].r, tbl[n].v, tbl[n].a0, tbl[n].a1, tbl[n].a2, tbl[n].d0, tbl[n].d1, tbl[n].d2);
            sample();
            chk($sformatf("t%0d_we", n),     64'(we1),        64'(tbl[n].e_we));
            chk($sformatf("t%0d_waddr", n),  64'(waddr1[0]),  64'(tbl[n].e_addr));
            chk($sformatf("t%0d_wrdata", n), 64'(wrdata1[0]), 64'(tbl[n].e_data));
            chk($sformatf("t%0d_idle", n),   64'(idle1),      64'(tbl[n].e_idle));
            chk($sformatf("t%0d_ready", n),  64'(rdy1),       64'(tbl[n].e_rdy));
            advance();
        end

        // Two write ports, same destination from src0 and src2: serialized over two cycles.
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
        sample(); advance();
        drive(0, 3'b101, 7, 0, 7, 32'hAAAA0000, 0, 32'hBBBB0000);
        sample(); advance();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        sample();
        chk("c1_we",     64'(we2),        64'(2'b01));
        chk("c1_waddr0", 64'(waddr2[0]),  64'(7));
        chk("c1_wdata0", 64'(wrdata2[0]), 64'(32'hAAAA0000));
        chk("c1_waddr1", 64'(waddr2[1]),  64'(0));
        advance();
        sample();
        chk("c2_we",     64'(we2),        64'(2'b01));
        chk("c2_waddr0", 64'(waddr2[0]),  64'(7));
        chk("c2_wdata0", 64'(wrdata2[0]), 64'(32'hBBBB0000));
        advance();
        sample();
        chk("c3_idle",   64'(idle2),      64'(1));
        chk("c3_we",     64'(we2),        64'(0));
        advance();

`ifdef WB_FWD_EN
        // Forwarding lookup while register 9 is written, then with a zero lookup address.
        drive(0, 3'b001, 9, 0, 0, 32'h55, 0, 0);
        sample(); advance();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        raddr[0] = 5'd9; raddr[1] = 5'd0;
        sample();
        chk("f1_hit0",  64'(hit1[0]), 64'(1));
        chk("f1_data0", 64'(fd1[0]),  64'(32'h55));
        chk("f1_hit1",  64'(hit1[1]), 64'(0));
        chk("f2_hit0",  64'(hit2[0]), 64'(1));
        chk("f2_data0", 64'(fd2[0]),  64'(32'h55));
        advance();
        drive(0, 3'b001, 9, 0, 0, 32'h66, 0, 0);
        raddr[0] = 5'd0;
        sample(); advance();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        sample();
        chk("f3_we",    64'(we1),     64'(1));
        chk("f3_hit0",  64'(hit1[0]), 64'(0));
        chk("f3_data0", 64'(fd1[0]),  64'(0));
        advance();
`endif

        // Randomized traffic with small address range for collisions and register-0 drops.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0), 3'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom);
`ifdef WB_FWD_EN
            raddr[0] = 5'($urandom_range(0, 3));
            raddr[1] = 5'($urandom_range(0, 3));
`endif
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_SRC, default 3, number of result producers (0 ALU, 1 MUL/DIV, 2 LSU); legal 2..8.
REQ-002 Parameter WRITE_PORTS, default 1, regfile write ports driven; legal 1..2.
REQ-003 Parameter READ_PORTS, default 2, lookup ports (used only with WB_FWD_EN).
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 src_valid  input  N_SRC  producer i offers a result.
REQ-007 src_waddr  input  N_SRC x reg_addr_t  destination register.
REQ-008 src_wdata  input  N_SRC x uint32_t  result data.
REQ-009 src_ready  output  N_SRC  producer i may transfer this cycle.
REQ-010 we  output  WRITE_PORTS  regfile write enable per port.
REQ-011 waddr  output  WRITE_PORTS x reg_addr_t  regfile write address.
REQ-012 wrdata  output  WRITE_PORTS x uint32_t  regfile write data.
REQ-013 idle  output  1  high when no buffered result exists.

Function
REQ-014 Each source SHALL own a one-entry buffer (buf_valid, buf_addr, buf_data).
REQ-015 Transfer occurs when src_valid[i] and src_ready[i] are both high at posedge; src_ready[i] = !buf_valid[i] | grant[i] (combinational).
REQ-016 A transfer with src_waddr[i]==0 SHALL be accepted and discarded; buffer not loaded, we never asserted for it.
REQ-017 A transfer with nonzero address SHALL load the buffer at that posedge; earliest we for it is the next cycle (latency 1).
REQ-018 Each cycle, up to WRITE_PORTS valid buffers SHALL be granted, scanning indices rr_ptr, rr_ptr+1, ... mod N_SRC; first grant to port 0, second to port 1.
REQ-019 A buffer whose buf_addr equals an already-granted entry's address in the same cycle SHALL NOT be granted that cycle.
REQ-020 For granted port k: we[k]=1, waddr[k]=buf_addr, wrdata[k]=buf_data, all combinational from buffer state; ungranted ports drive we=0, waddr=0, wrdata=0.
REQ-021 A granted buffer SHALL be cleared at the posedge unless the same source transfers again that cycle, in which case it is reloaded with the new result.
REQ-022 rr_ptr SHALL advance to (last granted index + 1) mod N_SRC when any grant occurs, else hold.
REQ-023 Fairness: a continuously valid buffer SHALL be granted within N_SRC cycles.
REQ-024 idle = !(OR of buf_valid).

Reset
REQ-025 On rst at posedge: all buf_valid=0, rr_ptr=0; buffered results are discarded, including mid-arbitration.
REQ-026 During and after reset: we=0, waddr=0, wrdata=0, idle=1, src_ready all 1.

Configuration
REQ-027 Macro WB_FWD_EN defined: adds inputs raddr (READ_PORTS x reg_addr_t), outputs fwd_hit (READ_PORTS), fwd_data (READ_PORTS x uint32_t); fwd_hit[r]=1 iff raddr[r]!=0 and some we[k] with waddr[k]==raddr[r]; fwd_data = that wrdata[k] (highest k if several), else 0; purely combinational.
REQ-028 Macro undefined: those ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, then src0 valid addr=5 data=0xDEADBEEF one cycle -> next cycle we[0]=1, waddr=5, wrdata=0xDEADBEEF; following cycle we=0, idle=1.
REQ-030 All three sources valid simultaneously (addr 1,2,3) from reset, WRITE_PORTS=1 -> writes addr 1,2,3 on three consecutive cycles; src_ready pattern per REQ-015.
REQ-031 src1 valid addr=0 data=0x1234 -> src_ready[1]=1, no we in following 3 cycles, idle stays 1.
REQ-032 WRITE_PORTS=2, src0 and src2 both addr=7 -> cycle 1 writes only src0 to 7, cycle 2 writes src2 to 7.
REQ-033 Three buffers valid, assert rst one cycle -> next cycle idle=1, we=0, no stale write ever appears.
REQ-034 WB_FWD_EN, raddr[0]=9 while src0 result addr=9 data=0x55 is written -> fwd_hit[0]=1, fwd_data[0]=0x55; raddr[0]=0 -> fwd_hit[0]=0.
